// File: rtl/esdi_serial_port.sv
// ESDI serial command/status engine serving NUM_DRIVES emulated drives on one cable.
// Receives 17-bit command frames (16 data + odd parity) over the TRANSFER REQ/ACK
// handshake and forwards them upstream, then returns a 16-bit status word plus odd
// parity to the host over the same handshake.
module esdi_serial_port #(
    parameter int unsigned NUM_DRIVES  = 2,
    parameter int unsigned BASE_ADDR   = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_DELAY   = 4,
    parameter int unsigned TIMEOUT     = 1 << 20
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [2:0]            esdi_drive_select,
    input  logic                  esdi_transfer_req,
    input  logic                  esdi_command_data,
    output logic                  esdi_transfer_ack,
    output logic                  esdi_confstat_data,
    output logic                  esdi_attention,
    output logic [NUM_DRIVES-1:0] esdi_drive_selected,
    output logic [NUM_DRIVES-1:0] esdi_command_complete,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [15:0]           cmd_word,
    output logic [2:0]            cmd_drive,
    output logic                  cmd_parity_err,
    input  logic                  sts_valid,
    input  logic [15:0]           sts_word,
    input  logic [NUM_DRIVES-1:0] attn_req,
    input  logic [NUM_DRIVES-1:0] busy_req
);

    localparam int unsigned   DW       = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [DW-1:0] DLY_LAST = DW'(ACK_DELAY - 1);
    localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    ADDR_LO  = 3'(BASE_ADDR);
    localparam logic [2:0]    ADDR_HI  = 3'(BASE_ADDR + NUM_DRIVES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD_BIT,
        S_CMD_HOLD,
        S_CMD_REL,
        S_CMD_WAIT,
        S_CMD_OUT,
        S_STS_WAIT,
        S_STS_NEXT,
        S_STS_BIT,
        S_STS_HOLD,
        S_STS_REL
    } state_t;

    // Cable input synchronisers
    logic [SYNC_STAGES-1:0]      req_sync;
    logic [SYNC_STAGES-1:0]      dat_sync;
    logic [SYNC_STAGES-1:0][2:0] sel_sync;
    logic                        req_prev;
    logic                        req_s;
    logic                        dat_s;
    logic [2:0]                  sel_s;
    logic                        req_rise;
    logic                        req_fall;
    logic                        sel_hit;
    logic [2:0]                  sel_idx;

    // Transfer engine state
    state_t          state, state_n;
    logic [DW-1:0]   dly_q, dly_n;
    logic [4:0]      bit_cnt_q, bit_cnt_n;
    logic [2:0]      drv_q, drv_n;
    logic [16:0]     rx_q, rx_n;
    logic [16:0]     tx_q, tx_n;
    logic            ack_q, ack_n;
    logic            conf_q, conf_n;
    logic            pend_q, pend_n;
    logic [TW-1:0]   tmo_q, tmo_n;
    logic            host_wait;
    logic            tmo_hit;
    logic            abort;

    // Per-drive status outputs
    logic [NUM_DRIVES-1:0] sel_q, sel_n;
    logic [NUM_DRIVES-1:0] cc_q, cc_n;
    logic                  attn_q, attn_n;
    logic                  xfer_active_n;

    // Synchroniser chains; REQ resets high so a REQ already asserted at reset
    // release never looks like a rising edge until it has been seen low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_sync <= '1;
            dat_sync <= '0;
            sel_sync <= '0;
            req_prev <= 1'b1;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], esdi_transfer_req};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], esdi_command_data};
            sel_sync <= {sel_sync[SYNC_STAGES-2:0], esdi_drive_select};
            req_prev <= req_sync[SYNC_STAGES-1];
        end
    end

    // Edge detection and address decode on the synchronised copies
    always_comb begin
        req_s    = req_sync[SYNC_STAGES-1];
        dat_s    = dat_sync[SYNC_STAGES-1];
        sel_s    = sel_sync[SYNC_STAGES-1];
        req_rise = req_s & ~req_prev;
        req_fall = ~req_s & req_prev;
        sel_hit  = (sel_s >= ADDR_LO) && (sel_s <= ADDR_HI);
        sel_idx  = sel_s - ADDR_LO;
    end

    // Transfer FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            dly_q     <= '0;
            bit_cnt_q <= '0;
            drv_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            ack_q     <= 1'b0;
            conf_q    <= 1'b0;
            pend_q    <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state     <= state_n;
            dly_q     <= dly_n;
            bit_cnt_q <= bit_cnt_n;
            drv_q     <= drv_n;
            rx_q      <= rx_n;
            tx_q      <= tx_n;
            ack_q     <= ack_n;
            conf_q    <= conf_n;
            pend_q    <= pend_n;
            tmo_q     <= tmo_n;
        end
    end

    // Transfer FSM next-state, handshake timing, shift registers and abort
    always_comb begin
        state_n   = state;
        dly_n     = dly_q;
        bit_cnt_n = bit_cnt_q;
        drv_n     = drv_q;
        rx_n      = rx_q;
        tx_n      = tx_q;
        ack_n     = ack_q;
        conf_n    = conf_q;
        pend_n    = pend_q;
        tmo_n     = tmo_q;
        host_wait = 1'b0;
        tmo_hit   = 1'b0;
        abort     = 1'b0;

        case (state)
            S_IDLE: begin
                ack_n     = 1'b0;
                conf_n    = 1'b0;
                pend_n    = 1'b0;
                bit_cnt_n = '0;
                dly_n     = '0;
                if (req_rise && sel_hit) begin
                    drv_n   = sel_idx;
                    rx_n    = '0;
                    state_n = S_CMD_BIT;
                end
            end
            S_CMD_BIT: begin
                if (dly_q == DLY_LAST) begin
                    dly_n   = '0;
                    rx_n    = {rx_q[15:0], dat_s};
                    ack_n   = 1'b1;
                    state_n = S_CMD_HOLD;
                end else begin
                    dly_n = dly_q + 1'b1;
                end
            end
            S_CMD_HOLD: begin
                host_wait = 1'b1;
                if (req_fall) begin
                    dly_n   = '0;
                    state_n = S_CMD_REL;
                end
            end
            S_CMD_REL: begin
                if (dly_q == DLY_LAST) begin
                    dly_n     = '0;
                    ack_n     = 1'b0;
                    bit_cnt_n = bit_cnt_q + 1'b1;
                    state_n   = (bit_cnt_q == 5'd16) ? S_CMD_OUT : S_CMD_WAIT;
                end else begin
                    dly_n = dly_q + 1'b1;
                end
            end
            S_CMD_WAIT: begin
                host_wait = 1'b1;
                if (req_rise) begin
                    dly_n   = '0;
                    state_n = S_CMD_BIT;
                end
            end
            S_CMD_OUT: begin
                // The host may already request the first status bit; remember it.
                if (req_rise) pend_n = 1'b1;
                if (cmd_ready) begin
                    bit_cnt_n = '0;
                    state_n   = S_STS_WAIT;
                end
            end
            S_STS_WAIT: begin
                if (req_rise) pend_n = 1'b1;
                if (sts_valid) begin
                    tx_n = {sts_word, ~^sts_word};
                    if (pend_q || req_rise) begin
                        pend_n  = 1'b0;
                        dly_n   = '0;
                        conf_n  = sts_word[15];
                        state_n = S_STS_BIT;
                    end else begin
                        state_n = S_STS_NEXT;
                    end
                end
            end
            S_STS_NEXT: begin
                host_wait = 1'b1;
                if (req_rise) begin
                    dly_n   = '0;
                    conf_n  = tx_q[16];
                    state_n = S_STS_BIT;
                end
            end
            S_STS_BIT: begin
                if (dly_q == DLY_LAST) begin
                    dly_n   = '0;
                    ack_n   = 1'b1;
                    state_n = S_STS_HOLD;
                end else begin
                    dly_n = dly_q + 1'b1;
                end
            end
            S_STS_HOLD: begin
                host_wait = 1'b1;
                if (req_fall) begin
                    dly_n   = '0;
                    state_n = S_STS_REL;
                end
            end
            S_STS_REL: begin
                if (dly_q == DLY_LAST) begin
                    dly_n     = '0;
                    ack_n     = 1'b0;
                    conf_n    = 1'b0;
                    tx_n      = {tx_q[15:0], 1'b0};
                    bit_cnt_n = bit_cnt_q + 1'b1;
                    state_n   = (bit_cnt_q == 5'd16) ? S_IDLE : S_STS_NEXT;
                end else begin
                    dly_n = dly_q + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Host-inactivity watchdog runs only while waiting on a host edge
        if (!host_wait || req_rise || req_fall) tmo_n = '0;
        else                                    tmo_n = tmo_q + 1'b1;
        tmo_hit = host_wait && (tmo_q == TMO_LAST);

        // Once upstream has taken the command, the abort takes effect from STS_WAIT
        abort = (state != S_IDLE)
              && !(state == S_CMD_OUT && cmd_ready)
              && (!sel_hit || (sel_idx != drv_q) || tmo_hit);

        if (abort) begin
            state_n   = S_IDLE;
            ack_n     = 1'b0;
            conf_n    = 1'b0;
            pend_n    = 1'b0;
            dly_n     = '0;
            bit_cnt_n = '0;
            tmo_n     = '0;
        end
    end

    // Per-drive selection, attention and command-complete next values
    always_comb begin
        sel_n         = '0;
        cc_n          = '0;
        attn_n        = 1'b0;
        xfer_active_n = (state_n == S_CMD_OUT)  || (state_n == S_STS_WAIT) ||
                        (state_n == S_STS_NEXT) || (state_n == S_STS_BIT)  ||
                        (state_n == S_STS_HOLD) || (state_n == S_STS_REL);
        for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
            sel_n[i] = (sel_s == 3'(BASE_ADDR + i));
            if (sel_hit && (sel_idx == 3'(i))) attn_n = attn_req[i];
            cc_n[i] = (xfer_active_n && (drv_n == 3'(i))) ? 1'b0 : ~busy_req[i];
        end
    end

    // Per-drive status registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel_q  <= '0;
            cc_q   <= '1;
            attn_q <= 1'b0;
        end else begin
            sel_q  <= sel_n;
            cc_q   <= cc_n;
            attn_q <= attn_n;
        end
    end

    // Output drive; command fields read as zero outside the offer window
    always_comb begin
        esdi_transfer_ack     = ack_q;
        esdi_confstat_data    = conf_q;
        esdi_attention        = attn_q;
        esdi_drive_selected   = sel_q;
        esdi_command_complete = cc_q;
        cmd_valid             = (state == S_CMD_OUT);
        cmd_word              = cmd_valid ? rx_q[16:1] : '0;
        cmd_drive             = cmd_valid ? drv_q : '0;
        cmd_parity_err        = cmd_valid & ~(^rx_q);
    end

endmodule

// File: tb/tb_esdi_serial_port.sv
// Scoreboard bench for esdi_serial_port: host-side REQ/ACK driver plus
// monitors that pop expected command and status words as the DUT presents them.
module tb_esdi_serial_port;

    localparam int unsigned NUM_DRIVES  = 2;
    localparam int unsigned BASE_ADDR   = 1;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned ACK_DELAY   = 4;
    localparam int unsigned TIMEOUT     = 200;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic [2:0]            esdi_drive_select = '0;
    logic                  esdi_transfer_req = 1'b0;
    logic                  esdi_command_data = 1'b0;
    logic                  esdi_transfer_ack;
    logic                  esdi_confstat_data;
    logic                  esdi_attention;
    logic [NUM_DRIVES-1:0] esdi_drive_selected;
    logic [NUM_DRIVES-1:0] esdi_command_complete;
    logic                  cmd_valid;
    logic                  cmd_ready = 1'b1;
    logic [15:0]           cmd_word;
    logic [2:0]            cmd_drive;
    logic                  cmd_parity_err;
    logic                  sts_valid = 1'b0;
    logic [15:0]           sts_word = '0;
    logic [NUM_DRIVES-1:0] attn_req = '0;
    logic [NUM_DRIVES-1:0] busy_req = '0;

    esdi_serial_port #(
        .NUM_DRIVES (NUM_DRIVES),
        .BASE_ADDR  (BASE_ADDR),
        .SYNC_STAGES(SYNC_STAGES),
        .ACK_DELAY  (ACK_DELAY),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .esdi_drive_select    (esdi_drive_select),
        .esdi_transfer_req    (esdi_transfer_req),
        .esdi_command_data    (esdi_command_data),
        .esdi_transfer_ack    (esdi_transfer_ack),
        .esdi_confstat_data   (esdi_confstat_data),
        .esdi_attention       (esdi_attention),
        .esdi_drive_selected  (esdi_drive_selected),
        .esdi_command_complete(esdi_command_complete),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_word             (cmd_word),
        .cmd_drive            (cmd_drive),
        .cmd_parity_err       (cmd_parity_err),
        .sts_valid            (sts_valid),
        .sts_word             (sts_word),
        .attn_req             (attn_req),
        .busy_req             (busy_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [2:0]  d;
        logic        e;
    } cmd_t;

    cmd_t        exp_cmd_q[$];
    logic [16:0] exp_sts_q[$];
    int          checks = 0;
    int          passes = 0;
    logic        sts_mon_en = 1'b0;
    logic        ack_prev = 1'b0;
    logic [16:0] sts_sh = '0;
    int          sts_cnt = 0;
    cmd_t        mon_e;
    logic [16:0] mon_s;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Command monitor: compare each accepted command against the scoreboard
    always @(negedge clk) begin
        #1;
        if (cmd_valid && cmd_ready) begin
            if (exp_cmd_q.size() == 0) begin
                checks++;
                $display("FAIL cmd_unexpected: got word %h drive %0d, expected no command", cmd_word, cmd_drive);
            end else begin
                mon_e = exp_cmd_q.pop_front();
                check("cmd_word", 32'(cmd_word), 32'(mon_e.w));
                check("cmd_drive", 32'(cmd_drive), 32'(mon_e.d));
                check("cmd_parity_err", 32'(cmd_parity_err), 32'(mon_e.e));
            end
        end
    end

    // Status monitor: capture confstat on each ACK rise while a status read is active
    always @(negedge clk) begin
        #1;
        if (!sts_mon_en) begin
            sts_cnt = 0;
        end else if (esdi_transfer_ack && !ack_prev) begin
            sts_sh = {sts_sh[15:0], esdi_confstat_data};
            sts_cnt++;
            if (sts_cnt == 17) begin
                sts_cnt = 0;
                if (exp_sts_q.size() == 0) begin
                    checks++;
                    $display("FAIL sts_unexpected: got %h, expected no status", sts_sh);
                end else begin
                    mon_s = exp_sts_q.pop_front();
                    check("sts_bits", 32'(sts_sh), 32'(mon_s));
                end
            end
        end
        ack_prev = esdi_transfer_ack;
    end

    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (esdi_transfer_ack !== lvl && n < 200);
    endtask

    task automatic host_bit(input logic d, inout int min_lat, inout int bad);
        int n;
        esdi_command_data = d;
        @(negedge clk);
        esdi_transfer_req = 1'b1;
        wait_ack(1'b1, n);
        if (esdi_transfer_ack !== 1'b1) bad++;
        else if (n < min_lat) min_lat = n;
        esdi_transfer_req = 1'b0;
        wait_ack(1'b0, n);
        if (esdi_transfer_ack !== 1'b0) bad++;
    endtask

    task automatic xfer17(input logic [16:0] bits, input string nm);
        int ml;
        int bad;
        ml  = 1000;
        bad = 0;
        for (int i = 16; i >= 0; i--) host_bit(bits[i], ml, bad);
        check({nm, "_handshake_timeouts"}, 32'(bad), 0);
        check({nm, "_min_ack_latency_ge_delay"}, 32'(ml >= int'(ACK_DELAY)), 1);
    endtask

    task automatic push_cmd(input logic [15:0] w, input logic [2:0] d, input logic e);
        cmd_t c;
        c.w = w;
        c.d = d;
        c.e = e;
        exp_cmd_q.push_back(c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int ml;
        int bad;

        // Reset values
        repeat (4) @(negedge clk);
        check("rst_ack", 32'(esdi_transfer_ack), 0);
        check("rst_confstat", 32'(esdi_confstat_data), 0);
        check("rst_attention", 32'(esdi_attention), 0);
        check("rst_selected", 32'(esdi_drive_selected), 0);
        check("rst_cmd_complete", 32'(esdi_command_complete), 32'h3);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_cmd_word", 32'(cmd_word), 0);
        resetn = 1'b1;

        // Select address 1 (drive 0) and check attention routing
        esdi_drive_select = 3'd1;
        attn_req = 2'b01;
        repeat (4) @(negedge clk);
        check("sel1_selected", 32'(esdi_drive_selected), 32'h1);
        check("sel1_attention", 32'(esdi_attention), 1);
        attn_req = 2'b00;

        // Command 0xA5C3 with good odd parity, accepted immediately
        push_cmd(16'hA5C3, 3'd0, 1'b0);
        xfer17({16'hA5C3, 1'b1}, "cmd_a5c3");
        repeat (2) @(negedge clk);
        check("a5c3_valid_dropped", 32'(cmd_valid), 0);
        check("a5c3_cc_low", 32'(esdi_command_complete), 32'h2);

        // Status 0x8001: REQ raised before status is available stays pending
        sts_mon_en = 1'b1;
        exp_sts_q.push_back({16'h8001, 1'b1});
        esdi_transfer_req = 1'b1;
        repeat (20) @(negedge clk);
        check("sts_pending_no_ack", 32'(esdi_transfer_ack), 0);
        sts_word  = 16'h8001;
        sts_valid = 1'b1;
        wait_ack(1'b1, n);
        check("sts_first_ack", 32'(esdi_transfer_ack), 1);
        esdi_transfer_req = 1'b0;
        wait_ack(1'b0, n);
        check("sts_mid_cc_low", 32'(esdi_command_complete), 32'h2);
        ml = 1000;
        bad = 0;
        for (int i = 0; i < 16; i++) host_bit(1'b0, ml, bad);
        check("sts_8001_handshake_timeouts", 32'(bad), 0);
        sts_valid = 1'b0;
        repeat (2) @(negedge clk);
        sts_mon_en = 1'b0;
        check("sts_done_cc_high", 32'(esdi_command_complete), 32'h3);
        check("sts_done_confstat", 32'(esdi_confstat_data), 0);

        // Bad parity still forwarded; held stable while upstream stalls
        cmd_ready = 1'b0;
        push_cmd(16'hA5C3, 3'd0, 1'b1);
        xfer17({16'hA5C3, 1'b0}, "cmd_badpar");
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_word !== 16'hA5C3 || cmd_parity_err !== 1'b1 || cmd_drive !== 3'd0)
                bad++;
        end
        check("stall_cmd_stable_cycles_bad", 32'(bad), 0);
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("stall_valid_dropped", 32'(cmd_valid), 0);

        // Reset in the middle of a 0xFFFF status read
        sts_word  = 16'hFFFF;
        sts_valid = 1'b1;
        ml = 1000;
        bad = 0;
        for (int i = 0; i < 5; i++) host_bit(1'b0, ml, bad);
        esdi_transfer_req = 1'b1;
        wait_ack(1'b1, n);
        check("midsts_ack_high", 32'(esdi_transfer_ack), 1);
        check("midsts_confstat", 32'(esdi_confstat_data), 1);
        check("midsts_cc_low", 32'(esdi_command_complete), 32'h2);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", 32'(esdi_transfer_ack), 0);
        check("rst_mid_confstat", 32'(esdi_confstat_data), 0);
        check("rst_mid_cc", 32'(esdi_command_complete), 32'h3);
        check("rst_mid_valid", 32'(cmd_valid), 0);
        sts_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("req_high_at_release_ignored", 32'(esdi_transfer_ack), 0);
        esdi_transfer_req = 1'b0;
        repeat (4) @(negedge clk);

        // Out-of-range address is ignored; address 2 selects drive 1
        esdi_drive_select = 3'd7;
        attn_req = 2'b11;
        repeat (4) @(negedge clk);
        check("addr7_selected", 32'(esdi_drive_selected), 0);
        check("addr7_attention", 32'(esdi_attention), 0);
        esdi_transfer_req = 1'b1;
        repeat (20) @(negedge clk);
        check("addr7_no_ack", 32'(esdi_transfer_ack), 0);
        esdi_transfer_req = 1'b0;
        esdi_drive_select = 3'd2;
        attn_req = 2'b10;
        repeat (4) @(negedge clk);
        check("addr2_selected", 32'(esdi_drive_selected), 32'h2);
        check("addr2_attention_on", 32'(esdi_attention), 1);
        attn_req = 2'b01;
        repeat (2) @(negedge clk);
        check("addr2_attention_off", 32'(esdi_attention), 0);
        attn_req = 2'b00;

        // Deselect after 8 bits aborts; the following command arrives clean
        ml = 1000;
        bad = 0;
        for (int i = 0; i < 8; i++) host_bit(i[0], ml, bad);
        esdi_command_data = 1'b1;
        @(negedge clk);
        esdi_transfer_req = 1'b1;
        wait_ack(1'b1, n);
        check("bit9_ack_high", 32'(esdi_transfer_ack), 1);
        esdi_drive_select = 3'd0;
        wait_ack(1'b0, n);
        check("deselect_ack_drop_within_limit", 32'(n <= int'(SYNC_STAGES + 2)), 1);
        esdi_transfer_req = 1'b0;
        repeat (6) @(negedge clk);
        check("deselect_no_cmd_valid", 32'(cmd_valid), 0);
        esdi_drive_select = 3'd2;
        repeat (4) @(negedge clk);
        push_cmd(16'h1234, 3'd1, 1'b0);
        xfer17({16'h1234, 1'b0}, "cmd_1234");
        repeat (2) @(negedge clk);
        check("d1_cc_low", 32'(esdi_command_complete), 32'h1);
        sts_mon_en = 1'b1;
        exp_sts_q.push_back({16'h0007, 1'b0});
        sts_word  = 16'h0007;
        sts_valid = 1'b1;
        xfer17(17'h0, "sts_0007");
        sts_valid = 1'b0;
        repeat (2) @(negedge clk);
        sts_mon_en = 1'b0;
        check("d1_cc_high", 32'(esdi_command_complete), 32'h3);
        busy_req = 2'b01;
        repeat (2) @(negedge clk);
        check("busy0_cc", 32'(esdi_command_complete), 32'h2);
        busy_req = 2'b00;

        // Host stalls mid-command past the timeout; next command arrives clean
        esdi_drive_select = 3'd1;
        repeat (4) @(negedge clk);
        ml = 1000;
        bad = 0;
        for (int i = 0; i < 3; i++) host_bit(1'b1, ml, bad);
        repeat (TIMEOUT + 60) @(negedge clk);
        push_cmd(16'h5A5A, 3'd0, 1'b0);
        xfer17({16'h5A5A, 1'b1}, "cmd_5a5a");
        repeat (2) @(negedge clk);
        check("5a5a_cc_low", 32'(esdi_command_complete), 32'h2);
        esdi_drive_select = 3'd0;
        repeat (6) @(negedge clk);
        check("abort_sts_wait_cc_high", 32'(esdi_command_complete), 32'h3);

        repeat (5) @(negedge clk);
        check("cmd_scoreboard_drained", 32'(exp_cmd_q.size()), 0);
        check("sts_scoreboard_drained", 32'(exp_sts_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
